fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch/decode front end of the simple processor; the reader side of the program ROM.
//  Drives rom_addr/rd, captures the 16-bit instruction word and splits it into opcode/reg/imm fields.
//  Offers each instruction to the execute stage through a valid/ready handshake.
//  Owns the PC, applies taken JZ branches and stops on HALT.
// PARAMETERS
//  M  16  instruction width: [15:12] opcode, [11:8] reg A, [7:0] immediate, [7:4] reg B
//  N  8   ROM address width (PC width); PC wraps modulo 2**N
// PORTS
//  clk          in   1  system clock, rising-edge logic
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  1-cycle pulse: begin or restart execution at PC=0 (IDLE/HALTED only)
//  rd           out  1  ROM read enable; the ROM samples it on the falling edge
//  rom_addr     out  N  ROM address; equals pc
//  rom_data     in   M  ROM read data; registered by the ROM on the falling edge while rd=1
//  instr_valid  out  1  decoded instruction is presented
//  instr_ready  in   1  execute accepts the instruction (transfer = valid & ready)
//  br_taken     in   1  qualified by transfer with opcode JZ: branch to imm[N-1:0]
//  opcode       out  4  ir[15:12]
//  reg_a        out  4  ir[11:8]
//  reg_b        out  4  ir[7:4]
//  imm          out  8  ir[7:0]
//  pc           out  N  address of the next instruction to fetch
//  halted       out  1  HALT (4'b1111) has been fetched; fetch is stopped
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=0, ir=0, rd=0, instr_valid=0, halted=0.
//  FSM: IDLE -> FETCH on start. FETCH -> LOAD always. LOAD -> HALTED if rom_data[15:12]==4'b1111,
//   else ISSUE. ISSUE -> FETCH on transfer. HALTED -> FETCH on start (pc=0, halted=0).
//  FETCH: rd=1, rom_addr=pc. The ROM registers memory[pc] on that cycle's falling edge.
//  LOAD: rd=0; ir<=rom_data; pc<=pc+1 (N-bit wrap, 2**N-1 -> 0).
//  ISSUE: instr_valid=1. Fields stay stable until the transfer. pc does not change while stalled.
//  Transfer with opcode==4'b0110 (JZ) and br_taken=1: pc<=imm[N-1:0] (overrides the incremented pc).
//   br_taken is ignored for every other opcode.
//  HALT is never presented to execute: halted=1 from the cycle after LOAD; rd stays 0.
//  Throughput is one instruction per 3 cycles when instr_ready is held at 1.
//  Latency from entering FETCH to instr_valid=1 is 2 cycles.
//  rd, instr_valid and halted are decoded from the state register (glitch-free, no logic after the flops).
//  start outside IDLE/HALTED is ignored. Reset mid-fetch aborts immediately; no partial instruction is issued.
//  Unknown opcodes are issued unchanged; illegal-op detection belongs to execute.
// STRUCTURE
//  Shared package cpu_pkg:
//   - opcode constants OP_MOVR=4'b0010, OP_MOVI=4'b0011, OP_ADD=4'b0100, OP_SUB=4'b0101,
//     OP_JZ=4'b0110, OP_RL=4'b0111, OP_ST=4'b1000, OP_HALT=4'b1111
//   - field bit positions
//   - state encoding IDLE/FETCH/LOAD/ISSUE/HALTED
//  Sub-module instr_decode: combinational ir -> opcode/reg_a/reg_b/imm, is_jz, is_halt.
//  Also reused by execute.
// TESTING (bench uses a behavioural ROM: negedge-registered, rd-gated, matching the program ROM)
//  1. Reset with rst_n=0 mid-FETCH -> rd=0, instr_valid=0, pc=0 immediately, before any clock edge.
//  2. ROM[0]=16'h300A, start, instr_ready=1 -> instr_valid 2 cycles after FETCH; opcode=3, reg_a=0,
//     imm=8'h0A; pc=1.
//  3. instr_ready=0 for 5 cycles in ISSUE -> fields/pc stable, rd=0 throughout; accepted on the 6th cycle.
//  4. ROM[4]=16'h6108 issued with br_taken=1 -> next rom_addr=8; with br_taken=0 -> next rom_addr=5.
//  5. br_taken=1 on ADD (16'h4010) -> ignored, next rom_addr=pc+1.
//  6. ROM[11]=16'hF00B -> no instr_valid for it; halted=1; rd stays 0 for 20 cycles.
//     start -> rom_addr=0, halted=0.
//  7. pc=8'hFF, non-branch -> pc wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple processor: opcodes, instruction field positions,
// fetch FSM states and the decoded-instruction record.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_MOVR = 4'b0010;
    localparam logic [3:0] OP_MOVI = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_RL   = 4'b0111;
    localparam logic [3:0] OP_ST   = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // reg B shares its bits with the upper nibble of the immediate
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] reg_a;
        logic [3:0] reg_b;
        logic [7:0] imm;
        logic       is_jz;
        logic       is_halt;
    } decoded_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of an instruction word into its fields plus the two
// opcode flags the front end and execute care about.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int M = INSTR_W
) (
    input  logic [M-1:0] ir_i,
    output logic [3:0]   opcode_o,
    output logic [3:0]   reg_a_o,
    output logic [3:0]   reg_b_o,
    output logic [7:0]   imm_o,
    output logic         is_jz_o,
    output logic         is_halt_o
);

    assign opcode_o  = ir_i[OP_MSB:OP_LSB];
    assign reg_a_o   = ir_i[RA_MSB:RA_LSB];
    assign reg_b_o   = ir_i[RB_MSB:RB_LSB];
    assign imm_o     = ir_i[IMM_MSB:IMM_LSB];
    assign is_jz_o   = (ir_i[OP_MSB:OP_LSB] == OP_JZ);
    assign is_halt_o = (ir_i[OP_MSB:OP_LSB] == OP_HALT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: reads the program ROM, holds the decoded instruction
// for execute behind a valid/ready handshake, owns the PC and stops on HALT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int M = 16,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         rd,
    output logic [N-1:0] rom_addr,
    input  logic [M-1:0] rom_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         br_taken,
    output logic [3:0]   opcode,
    output logic [3:0]   reg_a,
    output logic [3:0]   reg_b,
    output logic [7:0]   imm,
    output logic [N-1:0] pc,
    output logic         halted
);

    state_e         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    decoded_t       dec_q, dec_d;
    decoded_t       rom_dec;
    logic           rd_q, valid_q, halted_q;

    // Decode straight off the ROM so the HALT check and the field capture share one decoder;
    // the captured record then plays the role of the instruction register.
    instr_decode #(.M(M)) u_decode (
        .ir_i      (rom_data),
        .opcode_o  (rom_dec.opcode),
        .reg_a_o   (rom_dec.reg_a),
        .reg_b_o   (rom_dec.reg_b),
        .imm_o     (rom_dec.imm),
        .is_jz_o   (rom_dec.is_jz),
        .is_halt_o (rom_dec.is_halt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                dec_d   = rom_dec;
                pc_d    = pc_q + N'(1);
                state_d = rom_dec.is_halt ? HALTED : ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    state_d = FETCH;
                    // a taken branch replaces the already-incremented pc
                    if (dec_q.is_jz && br_taken) pc_d = N'(dec_q.imm);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status outputs are flops loaded from the next state, so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            dec_q    <= '0;
            rd_q     <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dec_q    <= dec_d;
            rd_q     <= (state_d == FETCH);
            valid_q  <= (state_d == ISSUE);
            halted_q <= (state_d == HALTED);
        end
    end

    assign rd          = rd_q;
    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign opcode      = dec_q.opcode;
    assign reg_a       = dec_q.reg_a;
    assign reg_b       = dec_q.reg_b;
    assign imm         = dec_q.imm;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a program-level model:
// a behavioural ROM and the expected PC walk through it.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rd;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [3:0]  opcode, reg_a, reg_b;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] mem [256];
    logic [7:0]  model_pc;
    bit          noisy;
    int          total = 0;
    int          bad   = 0;

    fetch_unit #(.M(16), .N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rd          (rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .opcode      (opcode),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .imm         (imm),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // program ROM: registers the addressed word on the falling edge while rd=1
    always @(negedge clk) if (rd) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge where the fetch of model_pc should be in progress.
    // Walks one instruction through fetch/load/issue and advances model_pc.
    task automatic run_instr(input int dly, input bit br, output bit hit_halt);
        logic [15:0] w;
        logic [7:0]  inc;
        w = mem[model_pc];
        inc = model_pc + 8'd1;
        hit_halt = 1'b0;
        chk("fetch_rd", rd, 1);
        chk("fetch_addr", rom_addr, model_pc);
        chk("fetch_valid", instr_valid, 0);
        @(negedge clk);
        chk("load_rd", rd, 0);
        chk("load_valid", instr_valid, 0);
        @(negedge clk);
        if (w[15:12] == 4'hF) begin
            chk("halt_flag", halted, 1);
            chk("halt_valid", instr_valid, 0);
            chk("halt_rd", rd, 0);
            chk("halt_pc", pc, inc);
            hit_halt = 1'b1;
            model_pc = inc;
            return;
        end
        chk("issue_valid", instr_valid, 1);
        chk("issue_opcode", opcode, w[15:12]);
        chk("issue_reg_a", reg_a, w[11:8]);
        chk("issue_reg_b", reg_b, w[7:4]);
        chk("issue_imm", imm, w[7:0]);
        chk("issue_pc", pc, inc);
        chk("issue_halted", halted, 0);
        for (int i = 0; i < dly; i++) begin
            instr_ready = 1'b0;
            br_taken    = 1'($urandom_range(0, 1));
            start       = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", instr_valid, 1);
            chk("stall_rd", rd, 0);
            chk("stall_pc", pc, inc);
            chk("stall_opcode", opcode, w[15:12]);
            chk("stall_imm", imm, w[7:0]);
        end
        instr_ready = 1'b1;
        br_taken    = br;
        @(negedge clk);
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        model_pc = (w[15:12] == 4'h6 && br) ? w[7:0] : inc;
    endtask

    initial begin
        bit h;
        logic [15:0] w;
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; br_taken = 1'b0; noisy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h3000 | 16'(i[7:0]);
        mem[8'h00] = 16'h300A;
        mem[8'h01] = 16'h4010;
        mem[8'h02] = 16'h6104;
        mem[8'h04] = 16'h6108;
        mem[8'h05] = 16'h6004;
        mem[8'h08] = 16'h600B;
        mem[8'h0B] = 16'hF00B;

        @(negedge clk);
        chk("rst_rd", rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a fetch takes effect without a clock edge
        pulse_start();
        chk("prefetch_rd", rd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd", rd, 0);
        chk("async_valid", instr_valid, 0);
        chk("async_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_rd", rd, 0);

        // directed program: stall, ignored branch on ADD, JZ not-taken/taken, HALT
        pulse_start();
        model_pc = 8'h00;
        run_instr(5, 1'b0, h);
        run_instr(0, 1'b1, h);
        run_instr(0, 1'b1, h);
        run_instr(0, 1'b0, h);
        run_instr(2, 1'b1, h);
        run_instr(0, 1'b1, h);
        run_instr(0, 1'b1, h);
        chk("jz_target", model_pc, 8'h0B);
        run_instr(0, 1'b0, h);
        chk("halt_reached", 32'(h), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_hold_rd", rd, 0);
            chk("halt_hold_valid", instr_valid, 0);
            chk("halt_hold_flag", halted, 1);
        end

        // restart from HALTED, branch to 0xFF, then wrap back to 0
        mem[8'h00] = 16'h60FF;
        mem[8'hFF] = 16'h3001;
        pulse_start();
        chk("restart_halted", halted, 0);
        chk("restart_addr", rom_addr, 0);
        model_pc = 8'h00;
        run_instr(0, 1'b1, h);
        run_instr(0, 1'b0, h);
        chk("wrap_model", model_pc, 8'h00);
        run_instr(1, 1'b0, h);

        // randomized programs with random back-pressure, branches and spurious starts
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h3;
            if ($urandom_range(0, 5) == 0) w[15:12] = 4'h6;
            mem[i] = w;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rand_rst_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        noisy = 1'b1;
        pulse_start();
        model_pc = 8'h00;
        for (int k = 0; k < 300; k++) begin
            run_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), h);
            if (h) begin
                @(negedge clk);
                chk("rand_halt_rd", rd, 0);
                chk("rand_halt_flag", halted, 1);
                pulse_start();
                model_pc = 8'h00;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
